// File: rtl/mms_pkg.sv
// Shared types and constants for the streaming min/max selector.
package mms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/mms_stream_if.sv
// Input element stream and output result stream of mms_stream.
interface mms_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8
);

  logic              select;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [IDX_W:0]    out_count;
  logic              out_trunc;

  // Source/sink side: drives elements and accepts results
  modport master (
    output select, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_count, out_trunc
  );

  // Selector side
  modport slave (
    input  select, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_count, out_trunc
  );

endinterface

// File: rtl/mms_cmp_sel.sv
// Strict unsigned compare: flags a candidate that beats the current best for the mode.
module mms_cmp_sel
  import mms_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_cand,
  input  logic [DATA_W-1:0] i_best,
  output logic              o_take_c
);

  // Strict compare so ties keep the earlier element
  always_comb begin
    o_take_c = 1'b0;
    if (i_mode == MODE_MIN) begin
      o_take_c = (i_cand < i_best);
    end else begin
      o_take_c = (i_cand > i_best);
    end
  end

endmodule

// File: rtl/mms_stream.sv
// Streaming min/max selector: tracks a frame's extreme value, its index and the frame length.
module mms_stream
  import mms_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mms_stream_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** IDX_W) - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_mode;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_trunc;
  logic [DATA_W-1:0] r_best;
  logic [IDX_W-1:0]  r_best_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_acc;
  logic              w_out_acc;
  logic              w_at_limit;
  logic              w_take;

  mms_cmp_sel #(
    .DATA_W (DATA_W)
  ) u_cmp_sel (
    .i_mode   (r_mode),
    .i_cand   (bus.in_data),
    .i_best   (r_best),
    .o_take_c (w_take)
  );

  // Handshake decode from registered state only
  always_comb begin
    w_in_acc   = bus.in_valid && r_in_ready;
    w_out_acc  = r_out_valid && bus.out_ready;
    w_at_limit = (r_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_acc) begin
          w_state_nxt = bus.in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (w_in_acc && (bus.in_last || w_at_limit)) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (w_out_acc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mode      <= MODE_MAX;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != OUT);
      r_out_valid <= (w_state_nxt == OUT);
      case (r_state)
        IDLE: begin
          if (w_in_acc) begin
            r_mode     <= bus.select;
            r_best     <= bus.in_data;
            r_best_idx <= '0;
            r_cnt      <= CNT_W'(1);
            r_trunc    <= 1'b0;
          end
        end
        ACC: begin
          if (w_in_acc) begin
            if (w_take) begin
              r_best     <= bus.in_data;
              r_best_idx <= r_cnt[IDX_W-1:0];
            end
            r_cnt   <= r_cnt + CNT_W'(1);
            r_trunc <= w_at_limit && !bus.in_last;
          end
        end
        OUT: begin
          if (w_out_acc) begin
            r_trunc <= 1'b0;
          end
        end
        default: r_trunc <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_best;
  assign bus.out_idx   = r_best_idx;
  assign bus.out_count = r_cnt;
  assign bus.out_trunc = r_trunc;

endmodule

// File: tb/tb_mms_stream.sv
// Scoreboard bench for mms_stream with a small index width so the length limit is hit often.
module tb_mms_stream;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 2;
  localparam int          MAX_LEN = 1 << IDX_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mms_stream_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  mms_stream #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    int cnt;
    int trunc;
  } exp_t;

  exp_t exp_q[$];
  int   frame_q[$];
  bit   frame_min;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Reference: a frame is a list; result is its extreme value and first position holding it
  function automatic bit model_accept(input int d, input bit last, input bit sel);
    int   ext;
    exp_t e;
    if (frame_q.size() == 0) frame_min = sel;
    frame_q.push_back(d);
    if (!(last || frame_q.size() == MAX_LEN)) return 1'b0;
    ext = frame_q[0];
    foreach (frame_q[i]) begin
      if (frame_min && frame_q[i] < ext) ext = frame_q[i];
      if (!frame_min && frame_q[i] > ext) ext = frame_q[i];
    end
    e.idx = -1;
    foreach (frame_q[i]) if (e.idx < 0 && frame_q[i] == ext) e.idx = i;
    e.data  = ext;
    e.cnt   = frame_q.size();
    e.trunc = last ? 0 : 1;
    exp_q.push_back(e);
    frame_q.delete();
    return 1'b1;
  endfunction

  // Monitor: every presented result must match the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        chk("in_ready_during_out", int'(bus.in_ready), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", int'(bus.out_valid), 0);
        end else begin
          chk("out_data",  int'(bus.out_data),  exp_q[0].data);
          chk("out_idx",   int'(bus.out_idx),   exp_q[0].idx);
          chk("out_count", int'(bus.out_count), exp_q[0].cnt);
          chk("out_trunc", int'(bus.out_trunc), exp_q[0].trunc);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Downstream ready: random unless held low
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int d, input bit last, input bit sel);
    bit acc;
    bit closed;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    bus.in_last  = last;
    bus.select   = sel;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      chk("send_timeout", int'(acc), 1);
    end else begin
      closed = model_accept(d, last, sel);
      if (closed) chk("out_valid_latency", int'(bus.out_valid), 1);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.select   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_out_idx",   int'(bus.out_idx),   0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_out_trunc", int'(bus.out_trunc), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", int'(bus.in_ready), 1);

    // Max frame with a tie, last on the limit beat
    send(3, 0, 0); send(17, 0, 0); send(9, 0, 0); send(17, 1, 0);
    // Min frame with a tie
    send(200, 0, 1); send(5, 0, 1); send(5, 0, 1); send(90, 1, 1);
    // select toggled after the first element
    send(10, 0, 0); send(50, 0, 1); send(2, 0, 0); send(60, 1, 1);
    drain();

    // Single element under backpressure; offered input must not be taken
    hold_ready = 1'b1;
    idle(2);
    send(42, 1, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(99);
    bus.in_last  = 1'b1;
    bus.select   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready",  int'(bus.in_ready),  0);
      chk("stall_out_valid", int'(bus.out_valid), 1);
    end
    hold_ready = 1'b0;
    send(99, 1, 0);
    drain();

    // Length limit closes the frame; next element opens a new one
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    send(5, 0, 0); send(8, 1, 0);
    drain();

    // Asynchronous reset mid-frame discards the partial frame
    send(11, 0, 0); send(12, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready",  int'(bus.in_ready),  0);
    chk("midrst_out_count", int'(bus.out_count), 0);
    chk("midrst_out_data",  int'(bus.out_data),  0);
    frame_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(7, 0, 0); send(1, 1, 0);
    drain();

    // Random frames with gaps, ties and random select per beat
    repeat (300) begin
      idle($urandom_range(0, 2));
      send(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) != 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mms_stream.md
Name: mms_stream

Overview:
- Streaming min/max selector: consumes a frame of DATA_W-bit numbers over a valid/ready input, one per cycle, and tracks the running extreme.
- Returns the frame's minimum or maximum, the index of the winning element and the frame length over a valid/ready output.
- Successor to the fixed 4-input combinational selector: frame length is arbitrary up to 2^IDX_W, the mode is latched per frame, and the winner's index is reported.
- Sits between a sample source and downstream statistics logic.

Parameters:
- DATA_W, 8, width of each number (unsigned).
- IDX_W, 8, width of element index; max frame length 2^IDX_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- select  input  1  mode, sampled with the first element of a frame: 1 = minimum, 0 = maximum.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept an element.
- in_data  input  DATA_W  unsigned number.
- in_last  input  1  marks the final element of the frame.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  frame min/max.
- out_idx  output  IDX_W  zero-based position of the winning element.
- out_count  output  IDX_W+1  number of elements in the frame (1..2^IDX_W).
- out_trunc  output  1  frame closed by length limit, not by in_last.

Behaviour:
- Interface and reset:
  - Reset is asynchronous and active-low on rst_n; one clock, clk.
  - Reset values: in_ready=0 while rst_n low, then 1 from the first cycle after release. out_valid=0, out_data=0, out_idx=0, out_count=0, out_trunc=0. FSM goes to IDLE.
  - Handshake: transfer occurs on a cycle with valid && ready. in_ready = (state != OUT), registered-state decode with no combinational path from out_ready.
- FSM states IDLE, ACC, OUT:
  - IDLE: on accept, latch mode <= select, best <= in_data, best_idx <= 0, cnt <= 1.
    - If in_last, go to OUT; otherwise go to ACC.
  - ACC: on accept, compare in_data against best. Update on strict in_data < best (min mode) or strict in_data > best (max mode).
    - Ties keep the earliest element.
    - cnt increments; the element's index is cnt before increment.
    - Go to OUT if in_last, or if this element's index equals 2^IDX_W-1 (set trunc=1 when in_last=0).
  - OUT: out_valid=1, with outputs taken from best/best_idx/cnt/trunc. Outputs are stable while out_valid && !out_ready.
    - On out_ready, go to IDLE and clear out_valid next cycle; trunc clears.
- select changes during ACC are ignored; the mode is fixed per frame.
- Latency: out_valid rises the cycle after the last element is accepted. Minimum frame period is cnt+1 cycles plus output stall.
- Single-element frame (first beat carries in_last) yields out_idx=0, out_count=1.
- in_valid gaps in ACC: hold all state.
- Frame reaching 2^IDX_W elements with in_last asserted on the final beat: out_trunc=0.
- rst_n asserted mid-frame or during OUT: the partial frame is discarded and no result is emitted.
- Arithmetic: unsigned comparison only. cnt is IDX_W+1 bits and cannot wrap.

Decomposition:
- Shared package mms_pkg holds:
  - state enum (IDLE, ACC, OUT);
  - mode constants MODE_MAX=1'b0, MODE_MIN=1'b1.
- One sub-module, mms_cmp_sel: combinational. Inputs are mode, candidate and current best. Output is the take flag (strict compare per mode).
- Everything else is a single sequential block.

Test Plan:
- Max frame: select=0, data 3,17,9,17 (last on 4th) -> out_data=17, out_idx=1, out_count=4, out_trunc=0.
- Min frame: select=1, data 200,5,5,90 -> out_data=5, out_idx=1, out_count=4. Then toggle select mid-frame on the next frame and check the result still follows the mode latched at the first element.
- Single element: select=1, data 42 with in_last -> out_valid the next cycle, out_data=42, out_idx=0, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_* stable, in_ready=0, an input offered is not accepted. Release -> in_ready=1 the next cycle.
- Length limit, IDX_W=2: 5 elements 1,2,3,4,5 with no in_last, select=0:
  - first result out_data=4, out_idx=3, out_count=4, out_trunc=1;
  - element 5 then starts a new frame.
- Reset mid-frame: 2 elements accepted, then pulse rst_n low asynchronously (between edges) -> outputs reset immediately. A new frame 7,1 (max) gives out_data=7, out_count=2.
